// File: rtl/uart_send_multi_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_send_multi_if
//
// Purpose:
//   Bundles the request/data side and the serial/status side of the
//   multi-byte UART transmitter so the transmitter and its upstream loop
//   logic can be connected through a single port.
//
// Signals:
//   send_en    upstream -> tx   send request, level; only its rising edge counts
//   send_data  upstream -> tx   8*NUM_BYTES-bit word, byte 0 in bits [7:0]
//   uart_txd   tx -> upstream   serial line, idle high
//   tx_busy    tx -> upstream   high from accept until the last stop bit ends
//
// Modports:
//   master  the requesting side (drives send_en / send_data)
//   slave   the transmitter (drives uart_txd / tx_busy)
//
// The NUM_BYTES given here must match the transmitter's NUM_BYTES.
// -----------------------------------------------------------------------------
interface uart_send_multi_if #(
    parameter int NUM_BYTES = 8
);

    logic                   send_en;
    logic [8*NUM_BYTES-1:0] send_data;
    logic                   uart_txd;
    logic                   tx_busy;

    modport master (
        output send_en,
        output send_data,
        input  uart_txd,
        input  tx_busy
    );

    modport slave (
        input  send_en,
        input  send_data,
        output uart_txd,
        output tx_busy
    );

endinterface : uart_send_multi_if

// File: rtl/uart_send_multi.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_send_multi
//
// Purpose:
//   Multi-byte UART transmitter. A rising edge on send_en (seen while idle)
//   latches the whole send_data word into a shadow register and serialises it
//   as NUM_BYTES back-to-back 8N1 frames, byte 0 first, each byte LSB first.
//   tx_busy stays high for the whole transfer, exactly NUM_BYTES*10*BPS_CNT
//   clocks, so upstream logic can hold off new requests. Requests that arrive
//   while a transfer is in progress are dropped, not queued.
//
// Parameters:
//   CLK_FREQ   sys_clk frequency in Hz
//   UART_BPS   line baud rate
//   NUM_BYTES  bytes per transfer (data width is 8*NUM_BYTES)
//
// Ports:
//   sys_clk    system clock
//   sys_rst_n  asynchronous active-low reset; forces the line high at once
//   bus        uart_send_multi_if.slave
//                send_en, send_data  (in)   request and word to send
//                uart_txd, tx_busy   (out)  serial line and busy status
//
// Timing:
//   send_en is sampled by a two-flop edge detector, so the start bit appears
//   two clocks after the send_en rise. Every bit, including start and stop,
//   is held for exactly BPS_CNT = CLK_FREQ/UART_BPS clocks, and the stop bit
//   of one byte is followed directly by the start bit of the next.
// -----------------------------------------------------------------------------
module uart_send_multi #(
    parameter int CLK_FREQ  = 50000000,
    parameter int UART_BPS  = 115200,
    parameter int NUM_BYTES = 8
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    uart_send_multi_if.slave    bus
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int CLK_W   = (BPS_CNT > 1)   ? $clog2(BPS_CNT)   : 1;
    localparam int BYTE_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int DATA_W  = 8 * NUM_BYTES;

    localparam logic [CLK_W-1:0]  CLK_LAST  = CLK_W'(BPS_CNT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

    // bit_cnt encoding of a frame: 0 = start, 1..8 = data, 9 = stop
    localparam logic [3:0] BIT_LAST_DATA = 4'd8;
    localparam logic [3:0] BIT_STOP      = 4'd9;

    // A bit period of one clock leaves no room for the counter to wrap.
    if (BPS_CNT < 2) begin : g_bad_bps_cnt
        $error("uart_send_multi: CLK_FREQ/UART_BPS must be at least 2");
    end
    if (NUM_BYTES < 1) begin : g_bad_num_bytes
        $error("uart_send_multi: NUM_BYTES must be at least 1");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e              state_q;
    logic                en_dly0_q;    // send_en delayed by one clock
    logic                en_dly1_q;    // send_en delayed by two clocks
    logic [DATA_W-1:0]   shadow_q;     // word captured at accept
    logic [CLK_W-1:0]    clk_cnt_q;    // clock within the current bit
    logic [3:0]          bit_cnt_q;    // bit within the current frame
    logic [BYTE_W-1:0]   byte_cnt_q;   // frame within the transfer
    logic                txd_q;
    logic                busy_q;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic                en_flag;
    logic                bit_end;
    logic                frame_end;
    logic                xfer_end;
    logic [7:0]          cur_byte;
    logic                line_d;       // line value for the bit that starts next

    assign en_flag = en_dly0_q & ~en_dly1_q;

    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path leaves a value unassigned and no latch is inferred.
        bit_end   = 1'b0;
        frame_end = 1'b0;
        xfer_end  = 1'b0;
        cur_byte  = shadow_q[{byte_cnt_q, 3'b000} +: 8];
        line_d    = 1'b1;

        bit_end   = (clk_cnt_q == CLK_LAST);
        frame_end = bit_end && (bit_cnt_q == BIT_STOP);
        xfer_end  = frame_end && (byte_cnt_q == BYTE_LAST);

        if (bit_cnt_q == BIT_STOP) begin
            // Stop bit ending: next is the start bit of the following byte.
            // Not used on the final byte, where the line returns to idle.
            line_d = 1'b0;
        end else if (bit_cnt_q == BIT_LAST_DATA) begin
            line_d = 1'b1;
        end else begin
            // bit_cnt_q = 0..7 here; the bit starting next carries data bit
            // bit_cnt_q of the current byte (LSB first).
            line_d = cur_byte[bit_cnt_q[2:0]];
        end
    end

    // -------------------------------------------------------------------------
    // Edge detector, FSM, counters and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            // NOTE: the shadow register is cleared along with the control
            // state so nothing from an aborted transfer survives a reset.
            state_q    <= ST_IDLE;
            en_dly0_q  <= 1'b0;
            en_dly1_q  <= 1'b0;
            shadow_q   <= '0;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so en_dly1_q takes
            // the old en_dly0_q and every register updates from pre-edge values.
            en_dly0_q <= bus.send_en;
            en_dly1_q <= en_dly0_q;

            unique case (state_q)
                ST_IDLE: begin
                    if (en_flag) begin
                        shadow_q   <= bus.send_data;
                        busy_q     <= 1'b1;
                        state_q    <= ST_SEND;
                        clk_cnt_q  <= '0;
                        bit_cnt_q  <= '0;
                        byte_cnt_q <= '0;
                        txd_q      <= 1'b0;            // start bit of byte 0
                    end
                end

                ST_SEND: begin
                    // en_flag is ignored here, including on the final edge.
                    if (!bit_end) begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end else begin
                        clk_cnt_q <= '0;
                        if (xfer_end) begin
                            state_q    <= ST_IDLE;
                            busy_q     <= 1'b0;
                            txd_q      <= 1'b1;
                            bit_cnt_q  <= '0;
                            byte_cnt_q <= '0;
                        end else if (frame_end) begin
                            bit_cnt_q  <= '0;
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                            txd_q      <= line_d;
                        end else begin
                            bit_cnt_q  <= bit_cnt_q + 4'd1;
                            txd_q      <= line_d;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.uart_txd = txd_q;
    assign bus.tx_busy  = busy_q;

endmodule : uart_send_multi

// File: tb/tb_uart_send_multi.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_send_multi
//
// Self-checking bench for uart_send_multi at CLK_FREQ=1 MHz, UART_BPS=100 kHz
// (10 clocks per bit, 100 per byte, 800 per transfer).
//
// A reference model turns each accepted request into the expected line
// waveform (a queue of per-clock line values built from the frame format) and
// is compared with uart_txd / tx_busy on every falling clock edge. Directed
// scenarios additionally measure start latency, busy length and decode the
// captured line back into bytes.
// -----------------------------------------------------------------------------
module tb_uart_send_multi;

    localparam int CLK_FREQ  = 1000000;
    localparam int UART_BPS  = 100000;
    localparam int NUM_BYTES = 8;
    localparam int BPS       = CLK_FREQ / UART_BPS;
    localparam int FRAME     = 10 * BPS;
    localparam int XFER      = NUM_BYTES * FRAME;

    logic sys_clk = 1'b0;
    logic sys_rst_n;

    uart_send_multi_if #(.NUM_BYTES(NUM_BYTES)) bus ();

    uart_send_multi #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS),
        .NUM_BYTES(NUM_BYTES)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus.slave)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: expected line value for each clock, as a queue
    // -------------------------------------------------------------------------
    bit exp_q[$];
    bit exp_txd  = 1'b1;
    bit exp_busy = 1'b0;
    bit en_s1    = 1'b0;   // send_en seen at the previous clock edge
    bit en_s2    = 1'b0;   // send_en seen two clock edges ago
    bit rise;
    bit was_busy;

    function automatic void load_word(input logic [63:0] d);
        for (int b = 0; b < NUM_BYTES; b++) begin
            for (int k = 0; k < 10; k++) begin
                bit v;
                if (k == 0)      v = 1'b0;
                else if (k == 9) v = 1'b1;
                else             v = d[8*b + k - 1];
                repeat (BPS) exp_q.push_back(v);
            end
        end
    endfunction

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            exp_q.delete();
            exp_txd  = 1'b1;
            exp_busy = 1'b0;
            en_s1    = 1'b0;
            en_s2    = 1'b0;
        end else begin
            // A request counts when send_en was low two edges ago and high one
            // edge ago, and only if the transmitter was idle before this edge.
            rise     = en_s1 && !en_s2;
            was_busy = exp_busy;
            en_s2    = en_s1;
            en_s1    = (bus.send_en === 1'b1);
            if (rise && !was_busy) load_word(bus.send_data);
            if (exp_q.size() > 0) begin
                exp_txd  = exp_q.pop_front();
                exp_busy = 1'b1;
            end else begin
                exp_txd  = 1'b1;
                exp_busy = 1'b0;
            end
        end
    end

    // Continuous comparison away from the active edge.
    always @(negedge sys_clk) begin
        check("txd_cycle",  bus.uart_txd, exp_txd);
        check("busy_cycle", bus.tx_busy,  exp_busy);
    end

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    logic line_buf [0:XFER+127];

    task automatic kick(input logic [63:0] d);
        bus.send_data = d;
        bus.send_en   = 1'b1;
    endtask

    // Counts falling edges until the start bit of a transfer is visible.
    task automatic sync_start(output int lat);
        lat = 0;
        do begin
            @(negedge sys_clk);
            lat++;
        end while (!(bus.tx_busy === 1'b1 && bus.uart_txd === 1'b0) && lat < 50);
    endtask

    task automatic decode(input logic [63:0] d, input string tag);
        for (int b = 0; b < NUM_BYTES; b++) begin
            logic [7:0] got;
            logic [7:0] exp_byte;
            int base;
            base     = b * FRAME;
            got      = '0;
            exp_byte = 8'((d >> (8 * b)) & 64'hFF);
            for (int k = 0; k < 8; k++) got[k] = line_buf[base + (k + 1) * BPS + BPS / 2];
            check($sformatf("%s_b%0d_start", tag, b), line_buf[base + BPS / 2], 1'b0);
            check($sformatf("%s_b%0d_data",  tag, b), got, exp_byte);
            check($sformatf("%s_b%0d_stop",  tag, b), line_buf[base + 9 * BPS + BPS / 2], 1'b1);
        end
    endtask

    // Call right after kick(): checks latency, busy length and decoded bytes.
    task automatic capture(input logic [63:0] d, input string tag);
        int lat;
        int len;
        sync_start(lat);
        check({tag, "_latency"}, lat, 2);
        len = 0;
        while (bus.tx_busy === 1'b1 && len < XFER + 100) begin
            line_buf[len] = bus.uart_txd;
            len++;
            @(negedge sys_clk);
        end
        check({tag, "_busy_len"}, len, XFER);
        decode(d, tag);
    endtask

    task automatic idle_window(input int n, input string tag);
        int lows;
        int busys;
        lows  = 0;
        busys = 0;
        repeat (n) begin
            @(negedge sys_clk);
            if (bus.uart_txd !== 1'b1) lows++;
            if (bus.tx_busy !== 1'b0)  busys++;
        end
        check({tag, "_txd_low"}, lows, 0);
        check({tag, "_busy"},    busys, 0);
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        int l;
        logic [63:0] d;

        bus.send_en   = 1'b0;
        bus.send_data = '0;
        sys_rst_n     = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("reset_txd",  bus.uart_txd, 1'b1);
        check("reset_busy", bus.tx_busy,  1'b0);
        sys_rst_n = 1'b1;

        // Line idle with no request.
        idle_window(2000, "idle");

        // Basic transfer, send_en held high afterwards.
        kick(64'h0123456789ABCDEF);
        capture(64'h0123456789ABCDEF, "basic");
        idle_window(1500, "hold_high");
        bus.send_en = 1'b0;
        repeat (5) @(negedge sys_clk);

        // New request and new data during byte 2 must not disturb the line.
        kick(64'h0123456789ABCDEF);
        fork
            capture(64'h0123456789ABCDEF, "busy_req");
            begin
                sync_start(l);
                repeat (250) @(negedge sys_clk);
                bus.send_en = 1'b0;
                repeat (3) @(negedge sys_clk);
                bus.send_data = 64'hFFFF_FFFF_FFFF_FFFF;
                bus.send_en   = 1'b1;
            end
        join
        idle_window(1500, "busy_req_after");
        bus.send_en = 1'b0;
        repeat (5) @(negedge sys_clk);

        // Edge detected on the very edge that ends the transfer: dropped.
        d = {$urandom, $urandom};
        kick(d);
        fork
            capture(d, "end_edge");
            begin
                sync_start(l);
                repeat (10) @(negedge sys_clk);
                bus.send_en = 1'b0;
                repeat (788) @(negedge sys_clk);
                bus.send_en = 1'b1;
            end
        join
        idle_window(1500, "end_edge_after");
        bus.send_en = 1'b0;
        repeat (5) @(negedge sys_clk);

        // Back-to-back: new rise 3 clocks after tx_busy falls.
        d = {$urandom, $urandom};
        kick(d);
        fork
            capture(d, "b2b_first");
            begin
                sync_start(l);
                repeat (100) @(negedge sys_clk);
                bus.send_en = 1'b0;
            end
        join
        repeat (3) @(negedge sys_clk);
        kick(64'hA5);
        capture(64'hA5, "b2b_second");
        bus.send_en = 1'b0;
        repeat (5) @(negedge sys_clk);

        // Reset mid-frame at clock 250 (data bit 4 of byte 2, forced to 0).
        d = {$urandom, $urandom} & ~(64'h1 << 20);
        kick(d);
        sync_start(l);
        check("rst_mid_latency", l, 2);
        repeat (250) @(negedge sys_clk);
        check("rst_mid_pre_txd", bus.uart_txd, 1'b0);
        #2 sys_rst_n = 1'b0;
        #1;
        check("rst_async_txd",  bus.uart_txd, 1'b1);
        check("rst_async_busy", bus.tx_busy,  1'b0);
        bus.send_en = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        kick(64'h55);
        capture(64'h55, "post_rst");
        bus.send_en = 1'b0;

        // Random words with random idle gaps.
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(3, 20)) @(negedge sys_clk);
            d = {$urandom, $urandom};
            kick(d);
            capture(d, $sformatf("rand%0d", i));
            bus.send_en = 1'b0;
        end

        idle_window(200, "final_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule : tb_uart_send_multi

// File: doc/uart_send_multi.md
Name: uart_send_multi

Overview:
- Multi-byte UART transmitter on the far side of the loopback send interface.
- Latches a NUM_BYTES-wide word on a rising edge of send_en and serialises it as NUM_BYTES back-to-back 8N1 frames on uart_txd.
- Reports tx_busy for the whole transfer so the upstream loop logic holds off new requests.

Parameters:
- CLK_FREQ, 50000000, sys_clk frequency in Hz.
- UART_BPS, 115200, line baud rate.
- NUM_BYTES, 8, bytes per transfer; data width is 8*NUM_BYTES.
- Derived constant BPS_CNT = CLK_FREQ/UART_BPS (integer division) is the clocks per bit. Must be >= 2; otherwise elaboration error.

Ports:
- sys_clk  input  1  system clock
- sys_rst_n  input  1  asynchronous active-low reset
- send_en  input  1  send request; level signal, only its rising edge matters
- send_data  input  8*NUM_BYTES  word to transmit; sampled only at accept
- uart_txd  output  1  serial line, idle high
- tx_busy  output  1  high from accept until last stop bit completes

Behaviour:
- Reset (async, sys_rst_n=0):
  - uart_txd=1, tx_busy=0.
  - State IDLE; all counters, shadow register and edge-detect flops cleared.
  - Takes effect immediately, including mid-frame: the line goes high with no partial bit completed.
- Edge detect:
  - en_d0 <= send_en; en_d1 <= en_d0; en_flag = en_d0 & ~en_d1.
  - Edge detection runs in all states.
- Accept:
  - On a clock edge where en_flag=1 and state=IDLE: latch send_data into the shadow register, tx_busy <= 1, state <= SEND, all counters <= 0, uart_txd <= 0 (start bit).
  - If send_en rises just before edge N, en_d0 is set at edge N and accept happens at edge N+1, so latency is 2 clocks from send_en rise to start bit.
  - en_flag while state=SEND is dropped, not queued.
- States: IDLE and SEND.
- Counters:
  - clk_cnt runs 0..BPS_CNT-1.
  - bit_cnt runs 0..9: 0 is start, 1-8 are data, 9 is stop.
  - byte_cnt runs 0..NUM_BYTES-1.
- Bit timing:
  - Each bit is held exactly BPS_CNT clocks.
  - When clk_cnt=BPS_CNT-1, clk_cnt wraps to 0 and bit_cnt advances.
  - uart_txd is registered and changes only on bit boundaries.
- Line value per bit:
  - bit_cnt=0: 0.
  - bit_cnt=k (1..8): shadow[8*byte_cnt + k-1], so data goes out LSB first.
  - bit_cnt=9: 1.
- Byte order: byte 0 (send_data[7:0]) is sent first, byte NUM_BYTES-1 last.
- No idle gap between frames: the stop bit of byte i is followed directly by the start bit of byte i+1.
- Completion:
  - At the end of the stop bit of byte NUM_BYTES-1: state <= IDLE, tx_busy <= 0, uart_txd stays 1.
  - tx_busy is high for exactly NUM_BYTES*10*BPS_CNT clocks.
- Simultaneous events:
  - If en_flag=1 on the same edge that ends the transfer, the request is dropped, because state is still SEND at that edge.
  - A new request is accepted only from an IDLE cycle onward.
- Data stability: send_data changes after accept have no effect; only the shadow register is transmitted.
- Holding send_en high indefinitely causes exactly one transfer.

Test Plan:
Bench parameters: CLK_FREQ=1000000, UART_BPS=100000, so BPS_CNT=10, 100 clocks per byte, 800 clocks per transfer.
- Basic transfer: send_data=64'h0123456789ABCDEF, send_en 0->1 and held high.
  - Start bit appears 2 clocks after the rise.
  - Decoded bytes are EF, CD, AB, 89, 67, 45, 23, 01, each bit 10 clocks wide.
  - tx_busy is high for exactly 800 clocks.
  - No second transfer occurs while send_en stays high.
- Request while busy: during byte 2, drop send_en, set send_data=64'hFFFF_FFFF_FFFF_FFFF, and raise send_en again.
  - Line still carries the original 0123456789ABCDEF bytes.
  - No transfer follows completion.
- Edge exactly at completion: raise send_en so that en_flag coincides with the final stop-bit edge.
  - tx_busy falls and the line stays 1.
  - No new start bit appears.
- Back-to-back: send_en falls during the transfer and rises 3 clocks after tx_busy falls, with send_data=64'hA5.
  - Second transfer starts 2 clocks after the rise.
  - Bytes sent are A5 then 00 x7.
- Reset mid-frame: assert sys_rst_n=0 at clock 250 of a transfer.
  - uart_txd=1 and tx_busy=0 asynchronously.
  - After release, a fresh edge with send_data=64'h55 sends 55 followed by 00 x7 cleanly.
- Line idle: after reset, with no send_en edge for 2000 clocks, uart_txd stays 1 and tx_busy stays 0.
